// File: rtl/pipe_step_gen_pkg.sv
// Shared constants for the single-step pipeline clock generator:
// FSM state encoding, step counter width and a counter-width helper.
package pipe_step_gen_pkg;

    localparam int STEP_W = 16;

    // HI is the only state with bit 0 set, so every state change
    // flips at most one bit of the pipeclk decode.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HI   = 2'b01,
        ST_LO   = 2'b10
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_step_gen_debounce_sync.sv
// Two-flop synchroniser followed by a stability debouncer; the
// debounced level only follows after DEBOUNCE_CYCLES steady cycles.
module debounce_sync
    import pipe_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          settled;

    assign differ  = (sync[1] != level);
    assign settled = differ && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (!differ) begin
                cnt <= '0;
            end else if (settled) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_step_gen.sv
// Debounced single-step / free-run pipeline clock generator.
// Define PIPE_STEP_RUN_EN to build the run_sw automatic-step mode.
module pipe_step_gen
    import pipe_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned RUN_DIV         = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_btn,
    input  logic              run_sw,
    output logic              pipeclk,
    output logic [STEP_W-1:0] step_count,
    output logic              busy
);

    localparam int unsigned PW = cnt_w(PULSE_CYCLES);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     pcnt;
    logic              pdone;
    logic [STEP_W-1:0] step_count_q;
    logic              step_level;
    logic              step_level_d;
    logic              step_rise;
    logic              step_req;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk  (clk),
        .reset(reset),
        .raw  (step_btn),
        .level(step_level)
    );

    assign step_rise = step_level && !step_level_d;

`ifdef PIPE_STEP_RUN_EN
    localparam int unsigned RW = cnt_w(RUN_DIV);
    localparam logic [RW-1:0] RLAST = RW'(RUN_DIV - 1);

    logic          run_level;
    logic [RW-1:0] run_cnt;
    logic          run_wrap;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk  (clk),
        .reset(reset),
        .raw  (run_sw),
        .level(run_level)
    );

    assign run_wrap = run_level && (run_cnt == RLAST);

    // Held at zero while run mode is off, so each entry restarts the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (!run_level || run_wrap) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign step_req = run_level ? run_wrap : step_rise;
`else
    logic unused_run_sw;

    assign unused_run_sw = run_sw;
    assign step_req      = step_rise;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (step_req) state_next = ST_HI;
            ST_HI:   if (pdone)    state_next = ST_LO;
            ST_LO:   if (pdone)    state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pipeclk    = (state == ST_HI);
        busy       = (state != ST_IDLE);
        step_count = step_count_q;
    end

    assign pdone = (pcnt == PLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt         <= '0;
            step_count_q <= '0;
            step_level_d <= 1'b0;
        end else begin
            step_level_d <= step_level;
            if (state == ST_IDLE || state_next != state) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (state == ST_IDLE && state_next == ST_HI) begin
                step_count_q <= step_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_step_gen.sv
// Scoreboard bench for pipe_step_gen: stimulus queues expected pulses,
// a monitor pops one per pipeclk rise and checks count and shape.
module tb_pipe_step_gen;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        step_btn = 1'b0;
    logic        run_sw   = 1'b0;
    logic        pipeclk;
    logic        busy;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] count;
        bit          full;
    } exp_t;

    exp_t sb[$];

    logic mon_prev;
    int   mon_hi;
    int   mon_lo;
    exp_t mon_e;

    pipe_step_gen #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (2),
        .RUN_DIV        (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_btn  (step_btn),
        .run_sw    (run_sw),
        .pipeclk   (pipeclk),
        .step_count(step_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [15:0] c, input bit full);
        exp_t e;
        e.count = c;
        e.full  = full;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n);
        step_btn = 1'b1;
        idle(n);
        step_btn = 1'b0;
    endtask

    // Reset is asserted mid-phase, away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_pipeclk", pipeclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", step_count, 0);
        idle(2);
        reset = 1'b1;
    endtask

    initial begin : monitor
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && pipeclk && !mon_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got count %0d want none",
                             step_count);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_count", step_count, mon_e.count);
                    chk("busy_at_rise", busy, 1);
                    if (mon_e.full) begin
                        mon_hi = 0;
                        while (pipeclk && mon_hi < 10) begin
                            mon_hi++;
                            @(negedge clk);
                        end
                        mon_lo = 0;
                        while (busy && !pipeclk && mon_lo < 10) begin
                            mon_lo++;
                            @(negedge clk);
                        end
                        chk("pulse_high_len", mon_hi, 2);
                        chk("pulse_low_len", mon_lo, 2);
                    end
                end
            end
            mon_prev = pipeclk;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin : stim
        int n;

        do_reset();

        // Long hold gives one step; a fresh press gives the next.
        expect_pulse(16'd1, 1'b1);
        press(20);
        idle(12);
        chk("hold_count", step_count, 1);
        expect_pulse(16'd2, 1'b1);
        press(8);
        idle(14);
        chk("repress_count", step_count, 2);

        do_reset();
        press(3);
        idle(15);
        chk("short_press", step_count, 0);

        // Short release while busy, then held again: still one step.
        do_reset();
        expect_pulse(16'd1, 1'b1);
        press(7);
        idle(2);
        press(12);
        idle(14);
        chk("bounce_count", step_count, 1);

        do_reset();
        force dut.step_count_q = 16'hFFFF;
        #1;
        release dut.step_count_q;
        chk("preload", step_count, 16'hFFFF);
        expect_pulse(16'd0, 1'b1);
        press(10);
        idle(12);
        chk("wrap_count", step_count, 0);

        // Button held through reset counts as a new press.
        step_btn = 1'b1;
        do_reset();
        expect_pulse(16'd1, 1'b1);
        idle(20);
        step_btn = 1'b0;
        idle(10);
        chk("held_reset_count", step_count, 1);

        // Reset during the second HI cycle kills the pulse at once.
        do_reset();
        expect_pulse(16'd1, 1'b0);
        step_btn = 1'b1;
        n = 0;
        while (!pipeclk && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hi_seen", pipeclk, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_pipeclk", pipeclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", step_count, 0);
        step_btn = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(10);
        chk("after_abort_count", step_count, 0);

`ifdef PIPE_STEP_RUN_EN
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            expect_pulse(16'(i), 1'b1);
        end
        run_sw = 1'b1;
        idle(30);
        press(10);
        idle(60);
        run_sw = 1'b0;
        idle(40);
        chk("run_count", step_count, 6);
`else
        do_reset();
        run_sw = 1'b1;
        idle(100);
        run_sw = 1'b0;
        idle(20);
        chk("run_ignored", step_count, 0);
`endif

        idle(10);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
